// File: rtl/freqmeter_pkg.sv
// Shared types and defaults for the frequency meter blocks.
package freqmeter_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_COUNT,
        FS_PUB
    } fs_state_e;

    localparam int FM_SYNC_DEF = 2;

endpackage

// File: rtl/freqmeter_fscnt_if.sv
// Meter-domain window/ack controls and the published snapshot of one clkin counter.
interface freqmeter_fscnt_if #(
    parameter int FW = 16
);
    logic        gate_tog;
    logic        ack_tog;
    logic [FW:0] cnt_q;
    logic        ovf_q;
    logic        lost_q;
    logic        done_tog;
    logic        busy;

    modport master (
        output gate_tog, ack_tog,
        input  cnt_q, ovf_q, lost_q, done_tog, busy
    );

    modport slave (
        input  gate_tog, ack_tog,
        output cnt_q, ovf_q, lost_q, done_tog, busy
    );
endinterface

// File: rtl/freqmeter_sync.sv
// Multi-flop synchroniser with asynchronous clear for single-bit level/toggle inputs.
module freqmeter_sync
    import freqmeter_pkg::*;
#(
    parameter int DEPTH = FM_SYNC_DEF
) (
    input  logic clkin,
    input  logic fsresetn,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clkin or negedge fsresetn) begin
        if (!fsresetn) sr <= '0;
        else           sr <= {sr[DEPTH-2:0], d};
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/freqmeter_fscnt.sv
// Counts clkin cycles while the meter gate is open and publishes the result
// to the meter domain over a toggle req/ack handshake.
//
//   state    | meaning
//   FS_IDLE  | waiting for a gate rise (or one registered during FS_PUB)
//   FS_COUNT | window open, saturating counter running
//   FS_PUB   | one cycle: publish snapshot if acked, else mark it lost
module freqmeter_fscnt
    import freqmeter_pkg::*;
#(
    parameter int FW   = 16,
    parameter int SYNC = FM_SYNC_DEF
) (
    input logic                 clkin,
    input logic                 fsresetn,
    freqmeter_fscnt_if.slave    bus
);

    localparam logic [FW:0] CNT_ONE = {{FW{1'b0}}, 1'b1};

    fs_state_e   state, state_nxt;
    logic        gs, gs_d, as_q;
    logic        rise, fall, acked, rise_pend;
    logic [FW:0] wcnt, cnt_r;
    logic        wovf, lost_pend;
    logic        ovf_r, lost_r, done_r, busy_r;

    freqmeter_sync #(.DEPTH(SYNC)) u_sync_gate (
        .clkin    (clkin),
        .fsresetn (fsresetn),
        .d        (bus.gate_tog),
        .q        (gs)
    );

    freqmeter_sync #(.DEPTH(SYNC)) u_sync_ack (
        .clkin    (clkin),
        .fsresetn (fsresetn),
        .d        (bus.ack_tog),
        .q        (as_q)
    );

    assign rise  = gs & ~gs_d;
    assign fall  = ~gs & gs_d;
    assign acked = (as_q == done_r);

    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE:  if (rise || rise_pend) state_nxt = FS_COUNT;
            FS_COUNT: if (fall)              state_nxt = FS_PUB;
            FS_PUB:                          state_nxt = FS_IDLE;
            default:                         state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge fsresetn) begin
        if (!fsresetn) begin
            state     <= FS_IDLE;
            gs_d      <= 1'b0;
            rise_pend <= 1'b0;
            wcnt      <= '0;
            wovf      <= 1'b0;
            lost_pend <= 1'b0;
            cnt_r     <= '0;
            ovf_r     <= 1'b0;
            lost_r    <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            gs_d      <= gs;
            busy_r    <= (state_nxt == FS_COUNT);
            rise_pend <= (state == FS_PUB) && rise;
            case (state)
                FS_IDLE: begin
                    if (rise || rise_pend) begin
                        // A rise held over from FS_PUB already spent one gate-high cycle.
                        wcnt <= rise_pend ? CNT_ONE : '0;
                        wovf <= 1'b0;
                    end
                end
                FS_COUNT: begin
                    if (!fall) begin
                        if (&wcnt) wovf <= 1'b1;
                        else       wcnt <= wcnt + CNT_ONE;
                    end
                end
                FS_PUB: begin
                    if (acked) begin
                        cnt_r     <= wcnt;
                        ovf_r     <= wovf;
                        lost_r    <= lost_pend;
                        lost_pend <= 1'b0;
                        done_r    <= ~done_r;
                    end else begin
                        lost_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cnt_q    = cnt_r;
    assign bus.ovf_q    = ovf_r;
    assign bus.lost_q   = lost_r;
    assign bus.done_tog = done_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_freqmeter_fscnt.sv
// Scoreboard bench for freqmeter_fscnt: a 16-bit and a 4-bit instance share clkin/reset.
module tb_freqmeter_fscnt;
    import freqmeter_pkg::*;

    typedef struct {
        int cnt;
        int tol;
        int ovf;
        int lost;
    } exp_t;

    logic clkin    = 1'b0;
    logic clk_en   = 1'b1;
    logic fsresetn = 1'b0;

    always #5 if (clk_en) clkin = ~clkin;

    freqmeter_fscnt_if #(.FW(16)) b16 ();
    freqmeter_fscnt_if #(.FW(4))  b4 ();

    freqmeter_fscnt #(.FW(16), .SYNC(FM_SYNC_DEF)) dut16 (
        .clkin    (clkin),
        .fsresetn (fsresetn),
        .bus      (b16)
    );

    freqmeter_fscnt #(.FW(4), .SYNC(FM_SYNC_DEF)) dut4 (
        .clkin    (clkin),
        .fsresetn (fsresetn),
        .bus      (b4)
    );

    exp_t q16[$];
    exp_t q4[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   auto16 = 1'b1;
    bit   auto4  = 1'b1;
    logic prev16 = 1'b0;
    logic prev4  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        n_vec++;
        if (act < exp - tol || act > exp + tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    function automatic void push16(input int cnt, input int tol, input int ovf, input int lost);
        exp_t e;
        e = '{cnt, tol, ovf, lost};
        q16.push_back(e);
    endfunction

    function automatic void push4(input int cnt, input int tol, input int ovf, input int lost);
        exp_t e;
        e = '{cnt, tol, ovf, lost};
        q4.push_back(e);
    endfunction

    // Monitors: a done_tog change is a publish; compare it with the oldest expectation.
    initial begin : mon16
        exp_t e;
        forever begin
            @(negedge clkin);
            if (!fsresetn) prev16 = 1'b0;
            else if (b16.done_tog !== prev16) begin
                prev16 = b16.done_tog;
                if (q16.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL pub16: unexpected publish, cnt_q=%0d", b16.cnt_q);
                end else begin
                    e = q16.pop_front();
                    chk("pub16_cnt",  int'(b16.cnt_q),  e.cnt,  e.tol);
                    chk("pub16_ovf",  int'(b16.ovf_q),  e.ovf,  0);
                    chk("pub16_lost", int'(b16.lost_q), e.lost, 0);
                end
                if (auto16) b16.ack_tog = b16.done_tog;
            end
        end
    end

    initial begin : mon4
        exp_t e;
        forever begin
            @(negedge clkin);
            if (!fsresetn) prev4 = 1'b0;
            else if (b4.done_tog !== prev4) begin
                prev4 = b4.done_tog;
                if (q4.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL pub4: unexpected publish, cnt_q=%0d", b4.cnt_q);
                end else begin
                    e = q4.pop_front();
                    chk("pub4_cnt",  int'(b4.cnt_q),  e.cnt,  e.tol);
                    chk("pub4_ovf",  int'(b4.ovf_q),  e.ovf,  0);
                    chk("pub4_lost", int'(b4.lost_q), e.lost, 0);
                end
                if (auto4) b4.ack_tog = b4.done_tog;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q16.size() != 0 || q4.size() != 0) && k < budget) begin
            @(posedge clkin);
            k++;
        end
        #1;
        n_vec++;
        if (q16.size() != 0 || q4.size() != 0) begin
            n_err++;
            $display("FAIL drain: pending %0d/%0d publishes after %0d cycles, want 0/0",
                     q16.size(), q4.size(), budget);
            q16.delete();
            q4.delete();
        end
    endtask

    task automatic win16(input int n);
        b16.gate_tog = 1'b1;
        repeat (n) @(posedge clkin);
        #1 b16.gate_tog = 1'b0;
    endtask

    task automatic win4(input int n);
        b4.gate_tog = 1'b1;
        repeat (n) @(posedge clkin);
        #1 b4.gate_tog = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        b16.gate_tog = 1'b0; b16.ack_tog = 1'b0;
        b4.gate_tog  = 1'b0; b4.ack_tog  = 1'b0;
        #1;
        chk("rst16_cnt",  int'(b16.cnt_q),    0, 0);
        chk("rst16_ovf",  int'(b16.ovf_q),    0, 0);
        chk("rst16_lost", int'(b16.lost_q),   0, 0);
        chk("rst16_done", int'(b16.done_tog), 0, 0);
        chk("rst16_busy", int'(b16.busy),     0, 0);
        chk("rst4_cnt",   int'(b4.cnt_q),     0, 0);
        chk("rst4_done",  int'(b4.done_tog),  0, 0);
        idle(3);
        fsresetn = 1'b1;
        idle(3);

        // Plain 100-cycle window, immediate ack.
        push16(100, 1, 0, 0);
        win16(100);
        drain(40);
        chk("t1_done", int'(b16.done_tog), 1, 0);
        chk("t1_busy", int'(b16.busy),     0, 0);

        // 4-bit instance: saturate at 31, then a normal short window.
        push4(31, 0, 1, 0);
        win4(40);
        drain(40);
        idle(5);
        push4(10, 1, 0, 0);
        win4(10);
        drain(40);

        // No ack between two windows: the second is dropped, the third reports it.
        auto16 = 1'b0;
        idle(5);
        push16(50, 1, 0, 0);
        win16(50);
        drain(40);
        idle(10);
        win16(70);
        idle(20);
        chk("t3_hold_cnt",  int'(b16.cnt_q),    50, 1);
        chk("t3_hold_done", int'(b16.done_tog), 0,  0);
        b16.ack_tog = b16.done_tog;
        auto16 = 1'b1;
        idle(8);
        push16(30, 1, 0, 1);
        win16(30);
        drain(40);
        idle(5);
        push16(40, 1, 0, 0);
        win16(40);
        drain(40);

        // Asynchronous reset in the middle of a window with clkin stopped.
        idle(5);
        b16.gate_tog = 1'b1;
        idle(100);
        chk("t4_busy_pre", int'(b16.busy), 1, 0);
        clk_en = 1'b0;
        #20;
        fsresetn = 1'b0;
        prev16 = 1'b0;
        prev4  = 1'b0;
        #1;
        chk("t4_cnt16",  int'(b16.cnt_q),    0, 0);
        chk("t4_ovf16",  int'(b16.ovf_q),    0, 0);
        chk("t4_lost16", int'(b16.lost_q),   0, 0);
        chk("t4_done16", int'(b16.done_tog), 0, 0);
        chk("t4_busy16", int'(b16.busy),     0, 0);
        chk("t4_cnt4",   int'(b4.cnt_q),     0, 0);
        b16.gate_tog = 1'b0; b16.ack_tog = 1'b0;
        b4.ack_tog   = 1'b0;
        #20;
        fsresetn = 1'b1;
        #10;
        clk_en = 1'b1;
        idle(5);
        push16(20, 1, 0, 0);
        win16(20);
        drain(40);
        chk("t4_done_after", int'(b16.done_tog), 1, 0);

        // Gate low for a single cycle between two windows.
        idle(5);
        push16(40, 1, 0, 0);
        push16(30, 1, 0, 0);
        b16.gate_tog = 1'b1;
        idle(40);
        b16.gate_tog = 1'b0;
        idle(1);
        win16(30);
        drain(60);
        chk("t5_done", int'(b16.done_tog), 1, 0);

        // clkin stalls with the gate open; publish only after it resumes and the gate closes.
        idle(5);
        push16(55, 1, 0, 0);
        b16.gate_tog = 1'b1;
        idle(30);
        clk_en = 1'b0;
        #300;
        chk("t6_stall_done", int'(b16.done_tog), 1,  0);
        chk("t6_stall_cnt",  int'(b16.cnt_q),    30, 1);
        clk_en = 1'b1;
        idle(25);
        b16.gate_tog = 1'b0;
        drain(40);
        chk("t6_done", int'(b16.done_tog), 0, 0);

        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
